// File: rtl/wb_hp_initiator_if.sv
// rtl/wb_hp_initiator_if.sv - command/response channels and Wishbone master signals of wb_hp_initiator
interface wb_hp_initiator_if;
    // command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    // Wishbone classic master side
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    logic        busy;

    // initiator view
    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i,
        output busy
    );

    // environment view: command source, response sink and Wishbone target
    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i,
        input  busy
    );
endinterface

// File: rtl/wb_hp_initiator.sv
// rtl/wb_hp_initiator.sv - Wishbone classic single-transfer initiator with ack timeout
module wb_hp_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_hp_initiator_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A zero timeout disables the guard; the counter then simply wraps unobserved.
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    // State and datapath registers; reset drops CYC/STB at once and discards any transfer.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Next-state: accept in IDLE, terminate on ack (wins over timeout) or timeout, drain response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    we_d    = bus.cmd_we;
                    sel_d   = bus.cmd_sel;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus.wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs decode registered state only, so nothing flows combinationally from inputs.
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.wbm_cyc_o = (state_q == ST_BUS);
    assign bus.wbm_stb_o = (state_q == ST_BUS);
    assign bus.wbm_we_o  = (state_q == ST_BUS) && we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_hp_initiator.sv
// tb/tb_wb_hp_initiator.sv - randomized transaction-level bench for wb_hp_initiator
module tb_wb_hp_initiator;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_hp_initiator_if bus();

    wb_hp_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // expected outputs after the most recent rising edge
    bit          chk_en = 1'b0;
    logic        e_cyc, e_we, e_cmd_ready, e_rsp_valid, e_rsp_err;
    logic [31:0] e_adr, e_dat, e_rsp_dat;
    logic [3:0]  e_sel;

    // observations gathered by the compare process
    int          cyc_seen = 0;
    int          busy_seen = 0;
    logic [31:0] last_rsp_dat = 32'h0;
    logic        last_rsp_err = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc",       32'(bus.wbm_cyc_o), 32'(e_cyc));
            chk("stb",       32'(bus.wbm_stb_o), 32'(e_cyc));
            chk("we",        32'(bus.wbm_we_o),  32'(e_we));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(e_cmd_ready));
            chk("busy",      32'(bus.busy),      32'(!e_cmd_ready));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp_valid));
            if (e_cyc) begin
                chk("adr", bus.wbm_adr_o, e_adr);
                chk("dat", bus.wbm_dat_o, e_dat);
                chk("sel", 32'(bus.wbm_sel_o), 32'(e_sel));
            end
            if (e_rsp_valid) begin
                chk("rsp_dat", bus.rsp_dat, e_rsp_dat);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e_rsp_err));
            end
            if (bus.wbm_cyc_o) cyc_seen++;
            if (!bus.cmd_ready) busy_seen++;
            if (bus.rsp_valid) begin
                last_rsp_dat = bus.rsp_dat;
                last_rsp_err = bus.rsp_err;
            end
        end
    end

    task automatic set_idle_exp();
        e_cyc = 1'b0; e_we = 1'b0; e_cmd_ready = 1'b1; e_rsp_valid = 1'b0;
    endtask

    // quiet cycles, optionally with stray acks that must be ignored
    task automatic idle_cycles(int n, bit spurious);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b0;
            bus.wbm_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.wbm_dat_i = $urandom;
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            set_idle_exp();
        end
        bus.wbm_ack_i = 1'b0;
    endtask

    // One command: accepted at edge E0, slave acks d cycles late, consumer stalls 'stall' cycles.
    // Model: bus phase lasts min(d+1, T) edges; response valid until the handshake edge.
    task automatic txn(bit we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                       int d, int stall, bit fix_rd, logic [31:0] rd_fix);
        int bus_len;
        int hs;
        bit ok;
        logic [31:0] rd;
        ok      = (d + 1 <= T);
        bus_len = ok ? d + 1 : T;
        hs      = bus_len + stall + 1;
        rd      = fix_rd ? rd_fix : $urandom;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        bus.wbm_ack_i = 1'b0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        cyc_seen  = 0;
        busy_seen = 0;
        for (int k = 0; k <= hs; k++) begin
            @(posedge clk); #1;
            e_cyc       = (k < bus_len);
            e_we        = e_cyc && we;
            e_adr       = adr;
            e_dat       = dat;
            e_sel       = sel;
            e_cmd_ready = (k >= hs);
            e_rsp_valid = (k >= bus_len) && (k < hs);
            e_rsp_err   = !ok;
            e_rsp_dat   = (ok && !we) ? rd : 32'h0;
            // stimulus for edge E(k+1)
            if (k < hs) begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_we    = 1'($urandom_range(0, 1));
                bus.cmd_adr   = $urandom;
                bus.cmd_dat   = $urandom;
                bus.cmd_sel   = 4'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (k < bus_len) bus.wbm_ack_i = (k == d);
            else             bus.wbm_ack_i = (k == d) || ($urandom_range(0, 2) == 0);
            bus.wbm_dat_i = (k == d) ? rd : $urandom;
            if (k >= bus_len && k < bus_len + stall) bus.rsp_ready = 1'b0;
            else if (k == bus_len + stall)           bus.rsp_ready = 1'b1;
            else                                     bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        bus.wbm_ack_i = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_dat = '0;
        bus.cmd_sel = '0; bus.rsp_ready = 1'b0; bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = '0;
        set_idle_exp();
        e_adr = '0; e_dat = '0; e_sel = '0; e_rsp_dat = '0; e_rsp_err = 1'b0;
        chk_en = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_adr", bus.wbm_adr_o, 32'h0);
        rst_n = 1'b1;
        idle_cycles(2, 1'b0);

        // write, two wait states
        txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 0, 1'b0, 32'h0);
        chk("wr_cyc_cycles", 32'(cyc_seen), 32'd3);
        chk("wr_rsp_err", 32'(last_rsp_err), 32'h0);
        chk("wr_rsp_dat", last_rsp_dat, 32'h0);

        // read, immediate ack
        txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 1'b1, 32'hDEAD_BEEF);
        chk("rd_rsp_dat", last_rsp_dat, 32'hDEAD_BEEF);
        chk("rd_not_ready_cycles", 32'(busy_seen), 32'd2);

        // slave never acks
        txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 50, 0, 1'b0, 32'h0);
        chk("to_cyc_cycles", 32'(cyc_seen), 32'd4);
        chk("to_rsp_err", 32'(last_rsp_err), 32'h1);
        chk("to_rsp_dat", last_rsp_dat, 32'h0);

        // ack on the final allowed cycle beats the timeout
        txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 3, 0, 1'b1, 32'h1234_5678);
        chk("late_ack_cycles", 32'(cyc_seen), 32'd4);
        chk("late_ack_err", 32'(last_rsp_err), 32'h0);
        chk("late_ack_dat", last_rsp_dat, 32'h1234_5678);

        // back-to-back with a stalled consumer
        txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 5, 1'b0, 32'h0);
        chk("stall_not_ready_cycles", 32'(busy_seen), 32'd8);
        txn(1'b1, 32'h3000_0014, 32'h0BAD_F00D, 4'h5, 0, 0, 1'b0, 32'h0);

        // stray acks while idle, then a normal read
        idle_cycles(6, 1'b1);
        txn(1'b0, 32'h3000_0018, 32'h0, 4'hF, 1, 0, 1'b1, 32'hCAFE_0001);
        chk("post_spurious_dat", last_rsp_dat, 32'hCAFE_0001);

        // reset in the middle of a bus cycle
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_adr = 32'h3000_0020;
        bus.cmd_dat = 32'h0; bus.cmd_sel = 4'hF; bus.wbm_ack_i = 1'b0;
        @(posedge clk); #1;
        e_cyc = 1'b1; e_we = 1'b0; e_adr = 32'h3000_0020; e_dat = 32'h0; e_sel = 4'hF;
        e_cmd_ready = 1'b0; e_rsp_valid = 1'b0;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_idle_exp();
        #1;
        chk("rst_mid_cyc", 32'(bus.wbm_cyc_o), 32'h0);
        chk("rst_mid_stb", 32'(bus.wbm_stb_o), 32'h0);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        bus.wbm_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.wbm_ack_i = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2, 1'b0);
        txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 0, 0, 1'b1, 32'h5555_AAAA);
        chk("post_rst_dat", last_rsp_dat, 32'h5555_AAAA);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            idle_cycles($urandom_range(0, 2), 1'b1);
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 6), $urandom_range(0, 3), 1'b0, 32'h0);
        end
        idle_cycles(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
